mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller directly downstream of the RISCV core, between the core and the byte-wide RAM/IO bus.
- Serves two word-oriented request ports: instruction fetch (IF) and load/store (LS).
- Turns each request into a sequence of single-byte accesses on mem_a/mem_dout/mem_din/mem_wr, assembles read data little-endian, and returns it with a one-cycle done pulse.

Parameters:
- ADDR_W, 32, width of request and bus addresses. Byte address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low the block freezes.
- if_valid  input  1  IF read request, held until if_done.
- if_addr  input  ADDR_W  IF word address, byte-granular.
- if_done  output  1  one-cycle pulse: if_data valid.
- if_data  output  32  fetched word.
- ls_valid  input  1  LS request, held until ls_done.
- ls_wr  input  1  1 = store, 0 = load.
- ls_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- ls_addr  input  ADDR_W  LS byte address.
- ls_wdata  input  32  store data; byte i = bits [8i+7:8i].
- ls_done  output  1  one-cycle pulse: load data valid or store complete.
- ls_rdata  output  32  load data, zero-extended; sign extension is the core's job.
- mem_din  input  8  RAM/IO read byte.
- mem_dout  output  8  write byte.
- mem_a  output  ADDR_W  byte address.
- mem_wr  output  1  1 = write.

Behaviour:
- Reset (rst_in=0, async):
  - State IDLE; all counters 0.
  - mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0.
  - A transfer in flight is abandoned with no done pulse.
- States:
  - IDLE: accept a request.
  - RUN: issue and capture bytes.
  - DONE: one-cycle done pulse, turnaround.
- Byte count n: IF always 4; LS 1, 2 or 4 from ls_size.
- Acceptance, only in IDLE with rdy_in=1, sampled at edge E0:
  - ls_valid has priority over if_valid.
  - Latch port, addr, wr, n and wdata; go to RUN.
  - A losing if_valid stays pending and is served after the LS DONE cycle.
- Issue:
  - After edge E0+i (i=0..n-1), mem_a = addr+i.
  - Store: mem_dout = wdata byte i, mem_wr=1.
  - Load/fetch: mem_wr=0.
- Read capture:
  - mem_din for address addr+i is valid in the cycle after it is driven.
  - Captured at edge E0+i+2 into result byte i; upper unused bytes are 0.
- Completion:
  - Read: last capture at edge E0+n+1; done pulse and data registered at the same edge.
  - Store: done asserted after edge E0+n; mem_wr=0 in that cycle.
  - In both cases the state is DONE for exactly one cycle, then IDLE.
- Latency:
  - Load/fetch: n+1 cycles from accept edge to done visible.
  - Store: n cycles.
- Turnaround:
  - No request is accepted in the DONE cycle.
  - The requester must drop valid at the edge that samples done.
- Outside RUN: mem_wr=0 and mem_a holds its last value.
- Data hold:
  - if_data/ls_rdata hold until the next completed read on that port.
  - ls_rdata is unchanged by stores.
- Address arithmetic: addr+i wraps, e.g. 0xFFFFFFFF+1 = 0x00000000.
- rdy_in=0:
  - No register updates: state, counters, mem_a, mem_dout, captured bytes and done all hold.
  - mem_wr output = mem_wr_reg AND rdy_in, so no write occurs while paused.
  - A done pulse frozen by a pause stays high until the next ready edge.
- IO addresses (mem_a[17:16]=11) are handled identically; each byte address is driven exactly once per request.

Test Plan:
- Fetch: if_valid, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a 0x100..0x103 on consecutive cycles; if_done 5 cycles after accept; if_data=0x00000513.
- Store word: ls_wr=1, size=10, addr=0x200, wdata=0xDEADBEEF -> mem_wr=1 for 4 cycles, bytes EF,BE,AD,DE at 0x200..0x203; ls_done after 4 cycles; no extra write.
- Load half: size=01, addr=0x1FFF, RAM=0x34,0x12 -> ls_rdata=0x00001234, done after 3 cycles. Store byte to 0x30000 value 0x41 -> exactly one write cycle.
- Arbitration: if_valid and ls_valid both high in IDLE -> LS served first, then one DONE cycle, then IF accepted; each done pulses once.
- Pause: drop rdy_in for 3 cycles mid word store -> mem_wr=0 during pause, mem_a held; 4 total write cycles, data correct.
- Reset: assert rst_in low mid word load -> outputs 0 immediately; no done; after release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and byte-bus signals of the memory controller.
//   IF port  : if_valid, if_addr -> if_done, if_data
//   LS port  : ls_valid, ls_wr, ls_size, ls_addr, ls_wdata -> ls_done, ls_rdata
//   RAM/IO   : mem_din -> mem_dout, mem_a, mem_wr
// Modport slave is the controller's view; master is the core/RAM side.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              ls_valid;
  logic              ls_wr;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: splits word-oriented IF/LS requests into single-byte RAM/IO accesses,
// assembles read data little-endian and returns it with a one-cycle done pulse.
//   clk_in : system clock
//   rst_in : asynchronous active-low reset
//   rdy_in : global ready, all state freezes while low
//   bus    : mem_ctrl_if.slave (request ports and byte bus)
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input logic       clk_in,
  input logic       rst_in,
  input logic       rdy_in,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;     // edges elapsed since accept
  logic [2:0]        r_n;       // bytes in this request
  logic              r_is_ls;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_if_done;
  logic              r_ls_done;
  logic [31:0]       r_if_data;
  logic [31:0]       r_ls_rdata;

  logic [2:0]  w_n;
  logic [1:0]  w_idx;
  logic [1:0]  w_cap;
  logic [31:0] w_merged;

  always_comb begin
    case (bus.ls_size)
      2'b00:   w_n = 3'd1;
      2'b01:   w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
  end

  assign w_idx = r_cnt[1:0];
  // Byte driven at count c is returned two edges later, so capture index is c-2.
  assign w_cap = r_cnt[1:0] - 2'd2;

  // Buffer with the byte arriving this cycle folded in, so the final capture
  // and the data register update happen on the same edge.
  always_comb begin
    w_merged = r_buf;
    w_merged[8*w_cap +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_n        <= 3'd0;
      r_is_ls    <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_data  <= 32'd0;
      r_ls_rdata <= 32'd0;
    end else if (rdy_in) begin
      case (r_state)
        IDLE: begin
          if (bus.ls_valid) begin
            r_state    <= RUN;
            r_cnt      <= 3'd1;
            r_n        <= w_n;
            r_is_ls    <= 1'b1;
            r_wr       <= bus.ls_wr;
            r_addr     <= bus.ls_addr;
            r_wdata    <= bus.ls_wdata;
            r_buf      <= 32'd0;
            r_mem_a    <= bus.ls_addr;
            r_mem_dout <= bus.ls_wdata[7:0];
            r_mem_wr   <= bus.ls_wr;
          end else if (bus.if_valid) begin
            r_state  <= RUN;
            r_cnt    <= 3'd1;
            r_n      <= 3'd4;
            r_is_ls  <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= bus.if_addr;
            r_buf    <= 32'd0;
            r_mem_a  <= bus.if_addr;
            r_mem_wr <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt < r_n) begin
            r_mem_a  <= r_addr + ADDR_W'(r_cnt);
            r_mem_wr <= r_wr;
            if (r_wr) r_mem_dout <= r_wdata[8*w_idx +: 8];
          end else begin
            r_mem_wr <= 1'b0;
          end
          if (!r_wr && r_cnt >= 3'd2) r_buf <= w_merged;
          if (r_wr && r_cnt == r_n) begin
            r_state   <= DONE;
            r_ls_done <= 1'b1;
          end
          if (!r_wr && r_cnt == r_n + 3'd1) begin
            r_state <= DONE;
            if (r_is_ls) begin
              r_ls_done  <= 1'b1;
              r_ls_rdata <= w_merged;
            end else begin
              r_if_done <= 1'b1;
              r_if_data <= w_merged;
            end
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_cnt     <= 3'd0;
          r_if_done <= 1'b0;
          r_ls_done <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_a    = r_mem_a;
  assign bus.mem_dout = r_mem_dout;
  assign bus.mem_wr   = r_mem_wr & rdy_in;
  assign bus.if_done  = r_if_done;
  assign bus.if_data  = r_if_data;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model plus a word-level reference memory;
// directed scenarios followed by randomized requests with random pauses.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus ();
  mem_ctrl #(.ADDR_W(32)) dut (.clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bus));

  logic [7:0]  ram   [logic [31:0]];
  logic [7:0]  ref_m [logic [31:0]];
  logic [31:0] aq[$];
  logic [39:0] wq[$];
  logic [31:0] exp_if, exp_ls;
  int n_chk = 0;
  int n_err = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : 8'h00;
  endfunction

  // Byte RAM: write on mem_wr, read data one cycle after the address; frozen with rdy.
  always @(posedge clk) begin
    if (rdy) begin
      aq.push_back(bus.mem_a);
      if (bus.mem_wr) begin
        wq.push_back({bus.mem_a, bus.mem_dout});
        ram[bus.mem_a] = bus.mem_dout;
      end
      bus.mem_din <= ram_rd(bus.mem_a);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pl(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_m[a] = d;
  endtask

  // pz: 0 no pause, 1 three-cycle pause after second edge, 2 random pauses.
  task automatic do_req(input bit is_ls, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input int pz,
                        input string tag);
    int n, k, pcnt;
    bit seen, other, paused;
    logic [31:0] exp_d, held_a;
    n = !is_ls ? 4 : (size == 2'b00 ? 1 : (size == 2'b01 ? 2 : 4));
    exp_d = 32'd0;
    for (int i = 0; i < n; i++) exp_d[8*i +: 8] = ref_rd(addr + i);
    if (is_ls && wr) for (int i = 0; i < n; i++) ref_m[addr + i] = wdata[8*i +: 8];
    rdy = 1'b1;
    if (is_ls) begin
      bus.ls_valid = 1'b1; bus.ls_wr = wr; bus.ls_size = size;
      bus.ls_addr = addr; bus.ls_wdata = wdata;
    end else begin
      bus.if_valid = 1'b1; bus.if_addr = addr;
    end
    aq.delete(); wq.delete();
    k = 0; pcnt = 0; seen = 0; other = 0; paused = 0; held_a = 32'd0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(posedge clk);
      if (rdy) k++;
      #1;
      if (is_ls ? bus.ls_done : bus.if_done) seen = 1;
      if (is_ls ? bus.if_done : bus.ls_done) other = 1;
      if (pz == 1 && !seen) begin
        if (pcnt > 0) begin
          chk({tag, "_pause_wr"}, {63'd0, bus.mem_wr}, 64'd0);
          chk({tag, "_pause_a"}, {32'd0, bus.mem_a}, {32'd0, held_a});
          pcnt--;
          if (pcnt == 0) rdy = 1'b1;
        end else if (!paused && k == 2) begin
          paused = 1; rdy = 1'b0; pcnt = 3; held_a = bus.mem_a;
        end
      end else if (pz == 2 && !seen) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
    end
    chk({tag, "_done"}, {63'd0, seen}, 64'd1);
    chk({tag, "_other_done"}, {63'd0, other}, 64'd0);
    chk({tag, "_latency"}, 64'(k - 1), 64'((is_ls && wr) ? n : n + 1));
    if (!(is_ls && wr)) begin
      if (is_ls) exp_ls = exp_d; else exp_if = exp_d;
    end
    chk({tag, "_if_data"}, {32'd0, bus.if_data}, {32'd0, exp_if});
    chk({tag, "_ls_rdata"}, {32'd0, bus.ls_rdata}, {32'd0, exp_ls});
    bus.ls_valid = 1'b0; bus.if_valid = 1'b0;
    rdy = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {62'd0, bus.if_done, bus.ls_done}, 64'd0);
    chk({tag, "_nwrites"}, 64'(wq.size()), 64'((is_ls && wr) ? n : 0));
    if (is_ls && wr)
      for (int i = 0; i < n && i < wq.size(); i++)
        chk({tag, "_wbyte"}, {24'd0, wq[i]}, {24'd0, addr + i, wdata[8*i +: 8]});
    chk({tag, "_atrace_len"}, {63'd0, aq.size() > n}, 64'd1);
    for (int i = 0; i < n && i + 1 < aq.size(); i++)
      chk({tag, "_atrace"}, {32'd0, aq[i+1]}, {32'd0, addr + i});
  endtask

  initial begin
    int cnt;
    bit bad;
    bus.if_valid = 0; bus.if_addr = 0; bus.ls_valid = 0; bus.ls_wr = 0;
    bus.ls_size = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.mem_din = 0;
    exp_if = 0; exp_ls = 0;
    for (int a = 'h3F0; a < 'h480; a++) pl(32'(a), 8'($urandom));

    #12;
    chk("rst_mem_a", {32'd0, bus.mem_a}, 64'd0);
    chk("rst_outs", {bus.mem_dout, bus.mem_wr, bus.if_done, bus.ls_done}, 64'd0);
    chk("rst_data", {bus.if_data, bus.ls_rdata}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    pl(32'h100, 8'h13); pl(32'h101, 8'h05); pl(32'h102, 8'h00); pl(32'h103, 8'h00);
    do_req(0, 0, 2'b00, 32'h100, 32'd0, 0, "fetch");
    chk("fetch_word", {32'd0, bus.if_data}, 64'h0000_0513);

    do_req(1, 1, 2'b10, 32'h200, 32'hDEADBEEF, 0, "st_word");
    chk("st_word_ram", {ram_rd(32'h203), ram_rd(32'h202), ram_rd(32'h201), ram_rd(32'h200)},
        64'hDEADBEEF);

    pl(32'h1FFF, 8'h34); pl(32'h2000, 8'h12);
    do_req(1, 0, 2'b01, 32'h1FFF, 32'd0, 0, "ld_half");
    chk("ld_half_val", {32'd0, bus.ls_rdata}, 64'h0000_1234);

    do_req(1, 1, 2'b00, 32'h30000, 32'h0000_0041, 0, "st_byte_io");
    do_req(1, 1, 2'b10, 32'h500, 32'hCAFE_F00D, 1, "st_pause");
    do_req(0, 0, 2'b00, 32'hFFFF_FFFE, 32'd0, 0, "fetch_wrap");

    // Arbitration: LS wins, IF accepted two edges after the LS done is visible.
    begin
      logic [31:0] e_ls, e_if;
      for (int i = 0; i < 4; i++) begin
        e_ls[8*i +: 8] = ref_rd(32'h400 + i);
        e_if[8*i +: 8] = ref_rd(32'h404 + i);
      end
      bus.ls_valid = 1; bus.ls_wr = 0; bus.ls_size = 2'b10; bus.ls_addr = 32'h400;
      bus.if_valid = 1; bus.if_addr = 32'h404;
      bad = 1;
      for (int t = 0; t < 20 && bad; t++) begin
        @(posedge clk); #1;
        if (bus.ls_done) bad = 0;
      end
      chk("arb_ls_done", {63'd0, !bad}, 64'd1);
      chk("arb_if_not_first", {63'd0, bus.if_done}, 64'd0);
      chk("arb_ls_data", {32'd0, bus.ls_rdata}, {32'd0, e_ls});
      bus.ls_valid = 0;
      cnt = 0; bad = 0;
      for (int t = 0; t < 20 && !bus.if_done; t++) begin
        @(posedge clk); #1;
        cnt++;
        if (bus.ls_done) bad = 1;
      end
      chk("arb_if_gap", 64'(cnt), 64'd7);
      chk("arb_ls_once", {63'd0, bad}, 64'd0);
      chk("arb_if_data", {32'd0, bus.if_data}, {32'd0, e_if});
      exp_ls = e_ls; exp_if = e_if;
      bus.if_valid = 0;
      @(posedge clk); #1;
      chk("arb_if_once", {63'd0, bus.if_done}, 64'd0);
    end

    // Reset mid word load: everything clears at once, no done afterwards.
    bus.ls_valid = 1; bus.ls_wr = 0; bus.ls_size = 2'b10; bus.ls_addr = 32'h410;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mrst_mem_a", {32'd0, bus.mem_a}, 64'd0);
    chk("mrst_outs", {bus.mem_dout, bus.mem_wr, bus.if_done, bus.ls_done}, 64'd0);
    chk("mrst_data", {bus.if_data, bus.ls_rdata}, 64'd0);
    exp_if = 0; exp_ls = 0;
    bus.ls_valid = 0;
    @(posedge clk); #2; rst_n = 1'b1;
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (bus.ls_done || bus.if_done || bus.mem_wr) bad = 1;
    end
    chk("mrst_quiet", {63'd0, bad}, 64'd0);
    do_req(0, 0, 2'b00, 32'h100, 32'd0, 0, "post_rst_fetch");

    for (int r = 0; r < 24; r++) begin
      bit     is_ls, wr;
      logic [31:0] a;
      is_ls = ($urandom_range(0, 2) != 0);
      wr    = is_ls && ($urandom_range(0, 1) == 1);
      a     = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                          : 32'h400 + $urandom_range(0, 96);
      do_req(is_ls, wr, 2'($urandom_range(0, 3)), a, $urandom, 2 * $urandom_range(0, 1),
             "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
